pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter BOOT_PC, default 32'h0000_0000: first fetch address after reset, word-aligned.
REQ-002 Parameter CNT_W, default 16: width of the mispredict counter.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 pred_i  input  prediction_t  BPU prediction for the current pc_o, combinational same cycle.
REQ-006 res_i  input  resolution_t  branch resolution from execute (valid, mispredict, taken, pc, target).
REQ-007 stall_i  input  1  decode backpressure; fetch record is not consumed.
REQ-008 imem_ready_i  input  1  instruction memory accepts the request this cycle.
REQ-009 pc_o  output  XLEN  current fetch PC, also drives the BPU pc_i.
REQ-010 imem_valid_o  output  1  fetch request valid; address is pc_o.
REQ-011 flush_o  output  1  pipeline/BPU flush, one-cycle pulse.
REQ-012 fetch_valid_o  output  1  fetch record valid toward decode.
REQ-013 fetch_pred_o  output  prediction_t  registered {pc, taken, target} of the accepted fetch.
REQ-014 mispred_cnt_o  output  CNT_W  count of resolved mispredictions.

Function
REQ-015 FSM states: BOOT, RUN, HOLD, FLUSH.
REQ-016 BOOT: entered on reset; imem_valid_o=0; goes to RUN unconditionally next cycle.
REQ-017 RUN: imem_valid_o=1; handshake fires when imem_valid_o & imem_ready_i & ~stall_i.
REQ-018 RUN on handshake: pc_q <= pred_i.taken ? pred_i.target : pc_q+4; fetch_pred_o <= pred_i; fetch_valid_o <= 1.
REQ-019 RUN without handshake: pc_q held, fetch_pred_o held, state -> HOLD; fetch_valid_o cleared only if stall_i=0.
REQ-020 HOLD: imem_valid_o=1, pc_o unchanged; returns to RUN on the handshake with the same update as REQ-018.
REQ-021 Mispredict = res_i.valid & res_i.mispredict; highest priority in every state except BOOT.
REQ-022 On mispredict: pc_q <= res_i.taken ? res_i.target : res_i.pc+4; fetch_valid_o <= 0; state -> FLUSH; any same-cycle handshake is discarded.
REQ-023 FLUSH: flush_o=1, imem_valid_o=0 for exactly one cycle, then RUN; a second mispredict in FLUSH reloads pc_q and stays FLUSH.
REQ-024 flush_o is 0 in all states other than FLUSH.
REQ-025 Mispredict in BOOT: pc_q reloaded as REQ-022, state -> FLUSH.
REQ-026 PC arithmetic modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0; pc_q[1:0] forced 2'b00.
REQ-027 mispred_cnt_o increments by 1 per mispredict cycle, saturates at all-ones.
REQ-028 Fetch latency: address accepted in cycle N appears on fetch_pred_o/fetch_valid_o in cycle N+1.
REQ-029 fetch_valid_o with stall_i=1 holds fetch_pred_o stable until stall_i=0.

Reset
REQ-030 Async reset: state=BOOT, pc_q=BOOT_PC, fetch_valid_o=0, fetch_pred_o=0, mispred_cnt_o=0, flush_o=0, imem_valid_o=0.
REQ-031 Reset mid-operation abandons any pending request; no fetch record survives reset.

Structure
REQ-032 prediction_t, resolution_t, XLEN, OFFSET and a pc_gen_state_t enum live in mmm_pkg.
REQ-033 Flat module, no sub-modules; the BPU is instantiated alongside it at fetch top level.

Verification
REQ-034 Reset release, BOOT_PC=0, ready=1, no predictions -> pc_o 0,4,8,... from cycle 2; fetch_pred_o.pc lags one cycle.
REQ-035 pred_i.taken=1, target=0x100 at pc 0x8 -> next pc_o=0x100, fetch_pred_o={0x8,1,0x100}.
REQ-036 imem_ready_i=0 for 3 cycles at pc 0x10 -> HOLD, pc_o stays 0x10, then 0x14 after ready.
REQ-037 Mispredict res {pc=0x20,taken=0} during HOLD -> flush_o pulse 1 cycle, imem_valid_o=0, then pc_o=0x24, fetch_valid_o=0, counter=1.
REQ-038 Back-to-back mispredicts (target 0x40 then 0x80) -> FLUSH extended, resume at 0x80, counter=2; counter at all-ones stays saturated.
REQ-039 pc 0xFFFF_FFFC not taken -> wraps to 0x0; reset asserted mid-HOLD -> BOOT_PC, all outputs at reset values.

Source files
------------

// File: rtl/mmm_pkg.sv
// Shared fetch-side types: BPU prediction record, execute-stage branch
// resolution, PC width/step and the PC generator state encoding.
package mmm_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] OFFSET = XLEN'(4);
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target;
    } prediction_t;

    typedef struct packed {
        logic            valid;
        logic            mispredict;
        logic            taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } resolution_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } pc_gen_state_t;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/pc_gen.sv
// Fetch PC generator: issues instruction-memory requests, follows BPU
// predictions, redirects on resolved mispredictions and registers the
// accepted fetch record toward decode.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BOOT  | first cycle after reset, no request issued
// ST_RUN   | request issued, previous request was accepted
// ST_HOLD  | request issued, re-presenting a PC that was not accepted
// ST_FLUSH | one-cycle flush pulse after a redirect, no request issued
module pc_gen
    import mmm_pkg::*;
#(
    parameter logic [XLEN-1:0] BOOT_PC = 32'h0000_0000,
    parameter int              CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  prediction_t        pred_i,
    input  resolution_t        res_i,
    input  logic               stall_i,
    input  logic               imem_ready_i,
    output logic [XLEN-1:0]    pc_o,
    output logic               imem_valid_o,
    output logic               flush_o,
    output logic               fetch_valid_o,
    output prediction_t        fetch_pred_o,
    output logic [CNT_W-1:0]   mispred_cnt_o
);

    pc_gen_state_t    state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    prediction_t      fetch_pred_q, fetch_pred_d;
    logic [CNT_W-1:0] cnt_q;

    logic             mispredict;
    logic             fetching;
    logic             handshake;
    logic [XLEN-1:0]  redirect_pc;
    logic [XLEN-1:0]  seq_pc;

    assign mispredict  = res_i.valid & res_i.mispredict;
    assign fetching    = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign handshake   = fetching & imem_ready_i & ~stall_i;
    assign redirect_pc = align_pc(res_i.taken ? res_i.target : res_i.pc + OFFSET);
    assign seq_pc      = align_pc(pred_i.taken ? pred_i.target : pc_q + OFFSET);

    // Next-state and datapath update; a mispredict overrides any handshake.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pred_d  = fetch_pred_q;
        if (mispredict) begin
            state_d       = ST_FLUSH;
            pc_d          = redirect_pc;
            fetch_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_BOOT, ST_FLUSH: state_d = ST_RUN;
                ST_RUN, ST_HOLD: begin
                    if (handshake) begin
                        state_d       = ST_RUN;
                        pc_d          = seq_pc;
                        fetch_pred_d  = pred_i;
                        fetch_valid_d = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        // With stall low decode consumed the record, so it retires.
                        if (!stall_i) begin
                            fetch_valid_d = 1'b0;
                        end
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    // State, PC and fetch record registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_BOOT;
            pc_q          <= align_pc(BOOT_PC);
            fetch_valid_q <= 1'b0;
            fetch_pred_q  <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pred_q  <= fetch_pred_d;
        end
    end

    // Saturating count of mispredict cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (mispredict && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign pc_o          = pc_q;
    assign imem_valid_o  = fetching;
    assign flush_o       = (state_q == ST_FLUSH);
    assign fetch_valid_o = fetch_valid_q;
    assign fetch_pred_o  = fetch_pred_q;
    assign mispred_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, hand sequences for counter
// saturation and mid-HOLD reset, then random stimulus against a model.
module tb_pc_gen;
    import mmm_pkg::*;

    localparam int               CNT_W   = 4;
    localparam logic [XLEN-1:0]  BOOT_PC = 32'h0000_0000;
    localparam int               CNT_LIM = (1 << CNT_W) - 1;
    localparam logic [XLEN-1:0]  G       = 32'hDEAD_BEE0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    prediction_t       pred;
    resolution_t       res;
    logic              stall;
    logic              ready;
    logic [XLEN-1:0]   pc;
    logic              imem_valid;
    logic              flush;
    logic              fetch_valid;
    prediction_t       fetch_pred;
    logic [CNT_W-1:0]  cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [XLEN-1:0] cur_pc = BOOT_PC;

    typedef struct {
        logic            ready, stall, p_taken;
        logic [XLEN-1:0] p_target;
        logic            r_valid, r_mis, r_taken;
        logic [XLEN-1:0] r_pc, r_target;
        logic [XLEN-1:0] e_pc;
        logic            e_iv, e_fl, e_fv;
        logic [XLEN-1:0] e_fpc;
        logic            e_ft;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    // model state
    logic            m_boot, m_flush, m_fv;
    logic [XLEN-1:0] m_pc;
    prediction_t     m_fp;
    int              m_cnt;

    pc_gen #(.BOOT_PC(BOOT_PC), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .pred_i       (pred),
        .res_i        (res),
        .stall_i      (stall),
        .imem_ready_i (ready),
        .pc_o         (pc),
        .imem_valid_o (imem_valid),
        .flush_o      (flush),
        .fetch_valid_o(fetch_valid),
        .fetch_pred_o (fetch_pred),
        .mispred_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int rdy, input int stl, input int pt, input logic [XLEN-1:0] ptgt,
                                input int rv, input int rm, input int rt,
                                input logic [XLEN-1:0] rpc, input logic [XLEN-1:0] rtgt,
                                input logic [XLEN-1:0] epc, input int eiv, input int efl, input int efv,
                                input logic [XLEN-1:0] efpc, input int eft, input int ecnt);
        vec_t v;
        v.ready = (rdy != 0); v.stall = (stl != 0); v.p_taken = (pt != 0); v.p_target = ptgt;
        v.r_valid = (rv != 0); v.r_mis = (rm != 0); v.r_taken = (rt != 0);
        v.r_pc = rpc; v.r_target = rtgt;
        v.e_pc = epc; v.e_iv = (eiv != 0); v.e_fl = (efl != 0); v.e_fv = (efv != 0);
        v.e_fpc = efpc; v.e_ft = (eft != 0); v.e_cnt = CNT_W'(ecnt);
        return v;
    endfunction

    // word-aligned address, computed arithmetically
    function automatic logic [XLEN-1:0] word_of(input logic [XLEN-1:0] a);
        return a - (a % 4);
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [XLEN-1:0] e_pc, input logic e_iv,
                                 input logic e_fl, input logic e_fv, input logic [XLEN-1:0] e_fpc,
                                 input logic e_ft, input logic [CNT_W-1:0] e_cnt);
        check({tag, ".pc"},          pc,                      e_pc);
        check({tag, ".imem_valid"},  XLEN'(imem_valid),       XLEN'(e_iv));
        check({tag, ".flush"},       XLEN'(flush),            XLEN'(e_fl));
        check({tag, ".fetch_valid"}, XLEN'(fetch_valid),      XLEN'(e_fv));
        check({tag, ".fp_pc"},       fetch_pred.pc,           e_fpc);
        check({tag, ".fp_taken"},    XLEN'(fetch_pred.taken), XLEN'(e_ft));
        check({tag, ".cnt"},         XLEN'(cnt),              XLEN'(e_cnt));
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic pt, input logic [XLEN-1:0] ptgt,
                         input logic [XLEN-1:0] ppc, input logic rv, input logic rm, input logic rt,
                         input logic [XLEN-1:0] rpc, input logic [XLEN-1:0] rtgt);
        ready = rdy; stall = stl;
        pred.pc = ppc; pred.taken = pt; pred.target = ptgt;
        res.valid = rv; res.mispredict = rm; res.taken = rt; res.pc = rpc; res.target = rtgt;
    endtask

    // entered and left in the low clock phase
    task automatic apply(input vec_t v, input string tag);
        drive(v.ready, v.stall, v.p_taken, v.p_target, cur_pc, v.r_valid, v.r_mis, v.r_taken, v.r_pc, v.r_target);
        @(posedge clk);
        #1;
        check_outputs(tag, v.e_pc, v.e_iv, v.e_fl, v.e_fv, v.e_fpc, v.e_ft, v.e_cnt);
        cur_pc = v.e_pc;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_flush = 1'b0; m_fv = 1'b0;
        m_pc = word_of(BOOT_PC); m_fp = '0; m_cnt = 0;
    endtask

    task automatic model_step();
        if (res.valid && res.mispredict) begin
            m_pc = word_of(res.taken ? res.target : res.pc + 32'd4);
            m_fv = 1'b0; m_boot = 1'b0; m_flush = 1'b1;
            if (m_cnt < CNT_LIM) m_cnt++;
        end else if (m_boot || m_flush) begin
            m_boot = 1'b0; m_flush = 1'b0;
        end else if (ready && !stall) begin
            m_fp = pred; m_fv = 1'b1;
            m_pc = word_of(pred.taken ? pred.target : m_pc + 32'd4);
        end else if (!stall) begin
            m_fv = 1'b0;
        end
    endtask

    task automatic model_check(input string tag);
        check_outputs(tag, m_pc, !m_boot && !m_flush, m_flush, m_fv, m_fp.pc, m_fp.taken, CNT_W'(m_cnt));
        check({tag, ".fp_target"}, fetch_pred.target, m_fp.target);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, G, BOOT_PC, 1'b0, 1'b0, 1'b0, '0, '0);

        //        rdy stl pt ptgt            rv rm rt rpc       rtgt          | epc           iv fl fv fpc           ft cnt
        vecs.push_back(mk(1,0,0,G,            0,0,0,'0,        '0,            32'h0,         1,0,0,32'h0,         0,0));
        vecs.push_back(mk(1,0,0,G,            0,0,0,'0,        '0,            32'h4,         1,0,1,32'h0,         0,0));
        vecs.push_back(mk(1,0,0,G,            0,0,0,'0,        '0,            32'h8,         1,0,1,32'h4,         0,0));
        vecs.push_back(mk(1,0,1,32'h100,      0,0,0,'0,        '0,            32'h100,       1,0,1,32'h8,         1,0));
        vecs.push_back(mk(1,0,1,32'h10,       0,0,0,'0,        '0,            32'h10,        1,0,1,32'h100,       1,0));
        vecs.push_back(mk(0,0,0,G,            0,0,0,'0,        '0,            32'h10,        1,0,0,32'h100,       1,0));
        vecs.push_back(mk(0,0,0,G,            0,0,0,'0,        '0,            32'h10,        1,0,0,32'h100,       1,0));
        vecs.push_back(mk(0,0,0,G,            0,0,0,'0,        '0,            32'h10,        1,0,0,32'h100,       1,0));
        vecs.push_back(mk(1,0,0,G,            0,0,0,'0,        '0,            32'h14,        1,0,1,32'h10,        0,0));
        vecs.push_back(mk(0,0,0,G,            0,0,0,'0,        '0,            32'h14,        1,0,0,32'h10,        0,0));
        vecs.push_back(mk(1,0,1,32'h300,      1,1,0,32'h20,    32'h999,       32'h24,        0,1,0,32'h10,        0,1));
        vecs.push_back(mk(1,0,0,G,            0,0,0,'0,        '0,            32'h24,        1,0,0,32'h10,        0,1));
        vecs.push_back(mk(1,0,0,G,            1,0,1,32'h50,    32'h60,        32'h28,        1,0,1,32'h24,        0,1));
        vecs.push_back(mk(1,0,0,G,            1,1,1,32'h30,    32'h40,        32'h40,        0,1,0,32'h24,        0,2));
        vecs.push_back(mk(1,0,0,G,            1,1,1,32'h44,    32'h80,        32'h80,        0,1,0,32'h24,        0,3));
        vecs.push_back(mk(1,0,0,G,            0,1,1,32'h70,    32'h500,       32'h80,        1,0,0,32'h24,        0,3));
        vecs.push_back(mk(1,0,0,G,            0,0,0,'0,        '0,            32'h84,        1,0,1,32'h80,        0,3));
        vecs.push_back(mk(1,1,0,G,            0,0,0,'0,        '0,            32'h84,        1,0,1,32'h80,        0,3));
        vecs.push_back(mk(0,1,0,G,            0,0,0,'0,        '0,            32'h84,        1,0,1,32'h80,        0,3));
        vecs.push_back(mk(1,0,0,G,            0,0,0,'0,        '0,            32'h88,        1,0,1,32'h84,        0,3));
        vecs.push_back(mk(1,0,1,32'hFFFF_FFFC,0,0,0,'0,        '0,            32'hFFFF_FFFC, 1,0,1,32'h88,        1,3));
        vecs.push_back(mk(1,0,0,G,            0,0,0,'0,        '0,            32'h0,         1,0,1,32'hFFFF_FFFC, 0,3));
        vecs.push_back(mk(1,0,1,32'h203,      0,0,0,'0,        '0,            32'h200,       1,0,1,32'h0,         1,3));
        vecs.push_back(mk(1,0,0,G,            1,1,1,32'h10,    32'h1007,      32'h1004,      0,1,0,32'h0,         1,4));
        vecs.push_back(mk(0,0,0,G,            0,0,0,'0,        '0,            32'h1004,      1,0,0,32'h0,         1,4));
        vecs.push_back(mk(0,0,0,G,            0,0,0,'0,        '0,            32'h1004,      1,0,0,32'h0,         1,4));

        repeat (3) @(negedge clk);
        #1;
        check_outputs("in_reset", BOOT_PC, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs("boot", BOOT_PC, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // repeated mispredicts: FLUSH held, counter climbs then saturates
        for (int k = 1; k <= 14; k++) begin
            int e;
            e = (4 + k > CNT_LIM) ? CNT_LIM : 4 + k;
            drive(1'b1, 1'b0, 1'b0, G, cur_pc, 1'b1, 1'b1, 1'b0, 32'h600, G);
            @(posedge clk);
            #1;
            check_outputs($sformatf("sat%0d", k), 32'h604, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, CNT_W'(e));
            cur_pc = 32'h604;
            @(negedge clk);
        end
        apply(mk(1,0,0,G, 0,0,0,'0,'0, 32'h604, 1,0,0,32'h0,   1,CNT_LIM), "post_sat_run");
        apply(mk(1,0,0,G, 0,0,0,'0,'0, 32'h608, 1,0,1,32'h604, 0,CNT_LIM), "post_sat_fetch");
        apply(mk(1,1,0,G, 0,0,0,'0,'0, 32'h608, 1,0,1,32'h604, 0,CNT_LIM), "pre_rst_hold");

        // asynchronous reset in the middle of HOLD with a live fetch record
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("rst_async", BOOT_PC, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        @(posedge clk);
        #1;
        check_outputs("rst_held", BOOT_PC, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // random stimulus against the model
        model_reset();
        for (int it = 0; it < 3000; it++) begin
            model_check("rnd");
            if (it == 1500) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                model_check("rnd_rst");
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end
            ready        = ($urandom_range(3) != 0);
            stall        = ($urandom_range(4) == 0);
            pred.pc      = m_pc;
            pred.taken   = ($urandom_range(3) == 0);
            pred.target  = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : $urandom;
            res.valid    = ($urandom_range(9) == 0);
            res.mispredict = ($urandom_range(1) == 1);
            res.taken    = ($urandom_range(1) == 1);
            res.pc       = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom;
            res.target   = $urandom;
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
        model_check("rnd_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
